// File: rtl/chipmunk_pkg.sv
// Shared types for the chipmunk accumulator CPU: FSM states, ALU ops, decode classes, opcodes.
// Opcodes 12/21 exist only when CHIPMUNK_INDEXED_EN is defined.
package chipmunk_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    ADDR_HI = 3'd2,
    MEM     = 3'd3,
    HALT    = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    ALU_LD, ALU_TFR, ALU_ADC, ALU_SBC, ALU_AND, ALU_ORA, ALU_EOR,
    ALU_CMP, ALU_INC, ALU_DEC, ALU_ASL, ALU_LSR, ALU_CLC, ALU_SEC
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_HLT, CLS_IMPL, CLS_IMM, CLS_ABS, CLS_ST, CLS_JMP
  } cls_t;

  typedef enum logic [1:0] {DST_NONE, DST_A, DST_X, DST_Y} dst_t;

  localparam logic [7:0] OP_HLT   = 8'h00;
  localparam logic [7:0] OP_LDA_I = 8'h10, OP_LDA_A = 8'h11, OP_LDX_I = 8'h18, OP_LDX_A = 8'h19;
  localparam logic [7:0] OP_LDY_I = 8'h1C, OP_LDY_A = 8'h1D;
  localparam logic [7:0] OP_STA_A = 8'h20, OP_STX_A = 8'h24, OP_STY_A = 8'h28;
`ifdef CHIPMUNK_INDEXED_EN
  localparam logic [7:0] OP_LDA_AX = 8'h12, OP_STA_AX = 8'h21;
`endif
  localparam logic [7:0] OP_ADC_I = 8'h30, OP_ADC_A = 8'h31, OP_SBC_I = 8'h34, OP_SBC_A = 8'h35;
  localparam logic [7:0] OP_AND_I = 8'h38, OP_AND_A = 8'h39, OP_ORA_I = 8'h3C, OP_ORA_A = 8'h3D;
  localparam logic [7:0] OP_EOR_I = 8'h40, OP_EOR_A = 8'h41, OP_CMP_I = 8'h44, OP_CMP_A = 8'h45;
  localparam logic [7:0] OP_INX = 8'h50, OP_INY = 8'h51, OP_DEX = 8'h52, OP_DEY = 8'h53;
  localparam logic [7:0] OP_TAX = 8'h54, OP_TXA = 8'h55, OP_TAY = 8'h56, OP_TYA = 8'h57;
  localparam logic [7:0] OP_CLC = 8'h58, OP_SEC = 8'h59, OP_ASL = 8'h5A, OP_LSR = 8'h5B;
  localparam logic [7:0] OP_JMP = 8'h60, OP_BEQ = 8'h61, OP_BNE = 8'h62, OP_BCS = 8'h63;
  localparam logic [7:0] OP_BCC = 8'h64, OP_BMI = 8'h65, OP_BPL = 8'h66;

endpackage

// File: rtl/chipmunk_alu.sv
// Combinational ALU: result and C for every op; Z/N always derived from the result.
module chipmunk_alu
  import chipmunk_pkg::*;
(
  input  alu_op_t    i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_m,
  input  logic       i_c,
  output logic [7:0] o_res,
  output logic       o_c,
  output logic       o_z,
  output logic       o_n
);

  logic [8:0] w_sum;

  always_comb begin
    w_sum = 9'd0;
    o_res = i_a;
    o_c   = i_c;
    case (i_op)
      ALU_LD:  o_res = i_m;
      ALU_TFR: o_res = i_a;
      ALU_ADC: begin
        w_sum = {1'b0, i_a} + {1'b0, i_m} + {8'd0, i_c};
        o_res = w_sum[7:0];
        o_c   = w_sum[8];
      end
      ALU_SBC: begin
        w_sum = {1'b0, i_a} + {1'b0, ~i_m} + {8'd0, i_c};
        o_res = w_sum[7:0];
        o_c   = w_sum[8];
      end
      // Carry out of A + ~M + 1 is exactly (A >= M).
      ALU_CMP: begin
        w_sum = {1'b0, i_a} + {1'b0, ~i_m} + 9'd1;
        o_res = w_sum[7:0];
        o_c   = w_sum[8];
      end
      ALU_AND: o_res = i_a & i_m;
      ALU_ORA: o_res = i_a | i_m;
      ALU_EOR: o_res = i_a ^ i_m;
      ALU_INC: o_res = i_a + 8'd1;
      ALU_DEC: o_res = i_a - 8'd1;
      ALU_ASL: begin
        o_res = {i_a[6:0], 1'b0};
        o_c   = i_a[7];
      end
      ALU_LSR: begin
        o_res = {1'b0, i_a[7:1]};
        o_c   = i_a[0];
      end
      ALU_CLC: o_c = 1'b0;
      ALU_SEC: o_c = 1'b1;
      default: o_res = i_a;
    endcase
    o_z = (o_res == 8'd0);
    o_n = o_res[7];
  end

endmodule

// File: rtl/chipmunk.sv
// chipmunk: 8-bit accumulator CPU, 12-bit address, multi-cycle FETCH/DECODE/ADDR_HI/MEM/HALT FSM.
// Define CHIPMUNK_INDEXED_EN to enable LDA abs,X (12) and STA abs,X (21).
module chipmunk
  import chipmunk_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] startPC,
  input  logic [7:0]  dataBus,
  output logic [7:0]  dataBusWrite,
  output logic [11:0] addrBus,
  output logic        weMem,
  output logic        done
);

  state_t      r_state, w_state_next;
  logic [11:0] r_pc, w_pc_next, r_ea, w_ea_next, w_pc_inc, w_ea_hi, w_ea_full;
  logic [7:0]  r_a, r_x, r_y, r_opcode, w_opcode_next;
  logic        r_z, r_n, r_c;
  cls_t        w_cls;
  alu_op_t     w_op;
  dst_t        w_dst;
  logic [7:0]  w_alu_a, w_st_data, w_alu_res, w_wdata;
  logic        w_zn, w_take, w_exec, w_we_n, w_alu_c, w_alu_z, w_alu_n;
`ifdef CHIPMUNK_INDEXED_EN
  logic        w_idx;
`endif

  // Instruction decode from the latched opcode.
  always_comb begin
    w_cls     = CLS_NOP;
    w_op      = ALU_LD;
    w_alu_a   = r_a;
    w_dst     = DST_NONE;
    w_zn      = 1'b1;
    w_take    = 1'b1;
    w_st_data = r_a;
`ifdef CHIPMUNK_INDEXED_EN
    w_idx     = 1'b0;
`endif
    case (r_opcode)
      OP_HLT:             w_cls = CLS_HLT;
      OP_LDA_I, OP_LDA_A: begin w_cls = r_opcode[0] ? CLS_ABS : CLS_IMM; w_dst = DST_A; end
      OP_LDX_I, OP_LDX_A: begin w_cls = r_opcode[0] ? CLS_ABS : CLS_IMM; w_dst = DST_X; end
      OP_LDY_I, OP_LDY_A: begin w_cls = r_opcode[0] ? CLS_ABS : CLS_IMM; w_dst = DST_Y; end
`ifdef CHIPMUNK_INDEXED_EN
      OP_LDA_AX:          begin w_cls = CLS_ABS; w_dst = DST_A; w_idx = 1'b1; end
      OP_STA_AX:          begin w_cls = CLS_ST; w_idx = 1'b1; end
`endif
      OP_STA_A:           w_cls = CLS_ST;
      OP_STX_A:           begin w_cls = CLS_ST; w_st_data = r_x; end
      OP_STY_A:           begin w_cls = CLS_ST; w_st_data = r_y; end
      OP_ADC_I, OP_ADC_A: begin w_cls = r_opcode[0] ? CLS_ABS : CLS_IMM; w_op = ALU_ADC; w_dst = DST_A; end
      OP_SBC_I, OP_SBC_A: begin w_cls = r_opcode[0] ? CLS_ABS : CLS_IMM; w_op = ALU_SBC; w_dst = DST_A; end
      OP_AND_I, OP_AND_A: begin w_cls = r_opcode[0] ? CLS_ABS : CLS_IMM; w_op = ALU_AND; w_dst = DST_A; end
      OP_ORA_I, OP_ORA_A: begin w_cls = r_opcode[0] ? CLS_ABS : CLS_IMM; w_op = ALU_ORA; w_dst = DST_A; end
      OP_EOR_I, OP_EOR_A: begin w_cls = r_opcode[0] ? CLS_ABS : CLS_IMM; w_op = ALU_EOR; w_dst = DST_A; end
      OP_CMP_I, OP_CMP_A: begin w_cls = r_opcode[0] ? CLS_ABS : CLS_IMM; w_op = ALU_CMP; end
      OP_INX: begin w_cls = CLS_IMPL; w_op = ALU_INC; w_alu_a = r_x; w_dst = DST_X; end
      OP_INY: begin w_cls = CLS_IMPL; w_op = ALU_INC; w_alu_a = r_y; w_dst = DST_Y; end
      OP_DEX: begin w_cls = CLS_IMPL; w_op = ALU_DEC; w_alu_a = r_x; w_dst = DST_X; end
      OP_DEY: begin w_cls = CLS_IMPL; w_op = ALU_DEC; w_alu_a = r_y; w_dst = DST_Y; end
      OP_TAX: begin w_cls = CLS_IMPL; w_op = ALU_TFR; w_dst = DST_X; end
      OP_TXA: begin w_cls = CLS_IMPL; w_op = ALU_TFR; w_alu_a = r_x; w_dst = DST_A; end
      OP_TAY: begin w_cls = CLS_IMPL; w_op = ALU_TFR; w_dst = DST_Y; end
      OP_TYA: begin w_cls = CLS_IMPL; w_op = ALU_TFR; w_alu_a = r_y; w_dst = DST_A; end
      OP_CLC: begin w_cls = CLS_IMPL; w_op = ALU_CLC; w_zn = 1'b0; end
      OP_SEC: begin w_cls = CLS_IMPL; w_op = ALU_SEC; w_zn = 1'b0; end
      OP_ASL: begin w_cls = CLS_IMPL; w_op = ALU_ASL; w_dst = DST_A; end
      OP_LSR: begin w_cls = CLS_IMPL; w_op = ALU_LSR; w_dst = DST_A; end
      OP_JMP: w_cls = CLS_JMP;
      OP_BEQ: begin w_cls = CLS_JMP; w_take = r_z;  end
      OP_BNE: begin w_cls = CLS_JMP; w_take = ~r_z; end
      OP_BCS: begin w_cls = CLS_JMP; w_take = r_c;  end
      OP_BCC: begin w_cls = CLS_JMP; w_take = ~r_c; end
      OP_BMI: begin w_cls = CLS_JMP; w_take = r_n;  end
      OP_BPL: begin w_cls = CLS_JMP; w_take = ~r_n; end
      default: w_cls = CLS_NOP;
    endcase
  end

  chipmunk_alu u_alu (
    .i_op  (w_op),
    .i_a   (w_alu_a),
    .i_m   (dataBus),
    .i_c   (r_c),
    .o_res (w_alu_res),
    .o_c   (w_alu_c),
    .o_z   (w_alu_z),
    .o_n   (w_alu_n)
  );

  assign w_pc_inc = r_pc + 12'd1;
  assign w_ea_hi  = {dataBus[3:0], r_ea[7:0]};
`ifdef CHIPMUNK_INDEXED_EN
  assign w_ea_full = w_idx ? (w_ea_hi + {4'd0, r_x}) : w_ea_hi;
`else
  assign w_ea_full = w_ea_hi;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_ea_next     = r_ea;
    w_opcode_next = r_opcode;
    w_exec        = 1'b0;
    w_we_n        = 1'b1;
    w_wdata       = 8'd0;
    addrBus       = r_pc;
    case (r_state)
      FETCH: begin
        w_opcode_next = dataBus;
        w_pc_next     = w_pc_inc;
        w_state_next  = DECODE;
      end
      DECODE: begin
        case (w_cls)
          CLS_HLT:  w_state_next = HALT;
          CLS_IMPL: begin w_exec = 1'b1; w_state_next = FETCH; end
          CLS_IMM:  begin w_exec = 1'b1; w_pc_next = w_pc_inc; w_state_next = FETCH; end
          CLS_ABS, CLS_ST, CLS_JMP: begin
            w_ea_next    = {r_ea[11:8], dataBus};
            w_pc_next    = w_pc_inc;
            w_state_next = ADDR_HI;
          end
          default:  w_state_next = FETCH;
        endcase
      end
      // Branch targets are never indexed; a not-taken branch keeps the incremented PC.
      ADDR_HI: begin
        w_pc_next = w_pc_inc;
        if (w_cls == CLS_JMP) begin
          if (w_take) w_pc_next = w_ea_hi;
          w_state_next = FETCH;
        end else begin
          w_ea_next    = w_ea_full;
          w_state_next = MEM;
        end
      end
      MEM: begin
        addrBus      = r_ea;
        w_state_next = FETCH;
        if (w_cls == CLS_ST) begin
          w_we_n  = 1'b0;
          w_wdata = w_st_data;
        end else begin
          w_exec = 1'b1;
        end
      end
      HALT:    w_state_next = HALT;
      default: w_state_next = FETCH;
    endcase
  end

  assign weMem        = w_we_n;
  assign dataBusWrite = w_wdata;
  assign done         = (r_state == HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FETCH;
      r_pc     <= startPC;
      r_ea     <= 12'd0;
      r_opcode <= 8'd0;
      r_a      <= 8'd0;
      r_x      <= 8'd0;
      r_y      <= 8'd0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_pc     <= w_pc_next;
      r_ea     <= w_ea_next;
      r_opcode <= w_opcode_next;
      if (w_exec) begin
        r_c <= w_alu_c;
        if (w_zn) begin
          r_z <= w_alu_z;
          r_n <= w_alu_n;
        end
        case (w_dst)
          DST_A:   r_a <= w_alu_res;
          DST_X:   r_x <= w_alu_res;
          DST_Y:   r_y <= w_alu_res;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chipmunk.sv
// Directed bench for chipmunk: small programs at 0x200, async-read memory with weMem-edge writes.
module tb_chipmunk;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] startPC = 12'h200;
  logic [7:0]  dataBus, dataBusWrite;
  logic [11:0] addrBus;
  logic        weMem, done;

  logic [7:0]  rom [0:4095];
  logic [7:0]  ram [0:4095];
  logic        ram_v [0:4095] = '{default: 1'b0};
  logic [7:0]  prog [$];
  int          wr_cnt = 0;
  logic [11:0] wr_addr = 12'd0;
  logic [7:0]  wr_data = 8'd0;
  int          checks = 0;
  int          errors = 0;
  int          base;

  chipmunk dut (
    .clk          (clk),
    .reset        (reset),
    .startPC      (startPC),
    .dataBus      (dataBus),
    .dataBusWrite (dataBusWrite),
    .addrBus      (addrBus),
    .weMem        (weMem),
    .done         (done)
  );

  always #5 clk = ~clk;

  assign dataBus = ram_v[addrBus] ? ram[addrBus] : rom[addrBus];

  // Hold address/data during the strobe; commit when weMem rises.
  always @(negedge clk) begin
    if (!weMem) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= addrBus;
      wr_data <= dataBusWrite;
    end
  end

  always @(posedge weMem) begin
    if (wr_cnt != 0) begin
      ram[wr_addr]   <= wr_data;
      ram_v[wr_addr] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load();
    for (int i = 0; i < 32; i++) rom[12'h200 + i] = (i < prog.size()) ? prog[i] : 8'h00;
  endtask

  task automatic do_reset(input logic [11:0] pc);
    startPC = pc;
    reset   = 1'b1;
    step(2);
    reset   = 1'b0;
  endtask

  task automatic run_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      step(1);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    step(2);
    check("rst_hold_addr", {20'd0, addrBus}, 32'h200);
    check("rst_hold_we", {31'd0, weMem}, 32'd1);
    check("rst_hold_wdata", {24'd0, dataBusWrite}, 32'd0);

    // Load and halt: done after 4 edges
    prog = '{8'h10, 8'h80, 8'h00};
    load();
    reset = 1'b0;
    check("rel_addr", {20'd0, addrBus}, 32'h200);
    check("rel_a", {24'd0, dut.r_a}, 32'd0);
    check("rel_x", {24'd0, dut.r_x}, 32'd0);
    check("rel_y", {24'd0, dut.r_y}, 32'd0);
    check("rel_done", {31'd0, done}, 32'd0);
    check("rel_we", {31'd0, weMem}, 32'd1);
    step(3);
    check("lda_done_early", {31'd0, done}, 32'd0);
    step(1);
    check("lda_done", {31'd0, done}, 32'd1);
    check("lda_a", {24'd0, dut.r_a}, 32'h80);
    check("lda_n", {31'd0, dut.r_n}, 32'd1);
    check("lda_z", {31'd0, dut.r_z}, 32'd0);

    // ADC overflow
    prog = '{8'h10, 8'hFF, 8'h30, 8'h01, 8'h00};
    load();
    do_reset(12'h200);
    run_done("adc_halt");
    check("adc_a", {24'd0, dut.r_a}, 32'h00);
    check("adc_z", {31'd0, dut.r_z}, 32'd1);
    check("adc_c", {31'd0, dut.r_c}, 32'd1);
    check("adc_n", {31'd0, dut.r_n}, 32'd0);

    // SEC then SBC #3 from 0x10
    prog = '{8'h10, 8'h10, 8'h59, 8'h34, 8'h03, 8'h00};
    load();
    do_reset(12'h200);
    run_done("sbc_halt");
    check("sbc_a", {24'd0, dut.r_a}, 32'h0D);
    check("sbc_c", {31'd0, dut.r_c}, 32'd1);

    // CMP equal keeps A
    prog = '{8'h10, 8'h05, 8'h44, 8'h05, 8'h00};
    load();
    do_reset(12'h200);
    run_done("cmp_halt");
    check("cmp_a", {24'd0, dut.r_a}, 32'h05);
    check("cmp_z", {31'd0, dut.r_z}, 32'd1);
    check("cmp_c", {31'd0, dut.r_c}, 32'd1);

    // ASL shifts bit 7 into C
    prog = '{8'h10, 8'h81, 8'h5A, 8'h00};
    load();
    do_reset(12'h200);
    run_done("asl_halt");
    check("asl_a", {24'd0, dut.r_a}, 32'h02);
    check("asl_c", {31'd0, dut.r_c}, 32'd1);

    // DEX wraps 0 -> FF
    prog = '{8'h52, 8'h00};
    load();
    do_reset(12'h200);
    run_done("dex_halt");
    check("dex_x", {24'd0, dut.r_x}, 32'hFF);
    check("dex_n", {31'd0, dut.r_n}, 32'd1);

    // Store then load back
    prog = '{8'h10, 8'h5A, 8'h20, 8'h45, 8'h03, 8'h19, 8'h45, 8'h03, 8'h00};
    load();
    do_reset(12'h200);
    base = wr_cnt;
    run_done("st_halt");
    check("st_count", wr_cnt - base, 32'd1);
    check("st_addr", {20'd0, wr_addr}, 32'h345);
    check("st_data", {24'd0, wr_data}, 32'h5A);
    check("ldx_back", {24'd0, dut.r_x}, 32'h5A);

    // Indexed store wraps to 0x001 (NOPs when the feature is off)
    prog = '{8'h18, 8'h03, 8'h10, 8'h07, 8'h21, 8'hFE, 8'h0F, 8'h00};
    load();
    do_reset(12'h200);
    base = wr_cnt;
    run_done("idx_halt");
`ifdef CHIPMUNK_INDEXED_EN
    check("idx_count", wr_cnt - base, 32'd1);
    check("idx_addr", {20'd0, wr_addr}, 32'h001);
    check("idx_data", {24'd0, wr_data}, 32'h07);
`else
    check("idx_nop_count", wr_cnt - base, 32'd0);
    check("idx_nop_a", {24'd0, dut.r_a}, 32'h07);
`endif

    // Branch taken / not taken
    prog = '{8'h10, 8'h00, 8'h61, 8'h10, 8'h02};
    load();
    do_reset(12'h200);
    step(5);
    check("beq_taken", {20'd0, addrBus}, 32'h210);
    prog = '{8'h10, 8'h01, 8'h61, 8'h10, 8'h02};
    load();
    do_reset(12'h200);
    step(5);
    check("beq_not_taken", {20'd0, addrBus}, 32'h205);

    // Reset during a store MEM cycle
    prog = '{8'h10, 8'h5A, 8'h20, 8'h45, 8'h03, 8'h00};
    load();
    do_reset(12'h200);
    step(5);
    check("mid_we_low", {31'd0, weMem}, 32'd0);
    check("mid_addr_ea", {20'd0, addrBus}, 32'h345);
    startPC = 12'h123;
    reset   = 1'b1;
    step(1);
    check("mid_rst_addr", {20'd0, addrBus}, 32'h123);
    check("mid_rst_we", {31'd0, weMem}, 32'd1);
    check("mid_rst_a", {24'd0, dut.r_a}, 32'd0);
    reset = 1'b0;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
